// File: rtl/pixel_write_buffer.sv
// ============================================================================
// Module      : pixel_write_buffer
// Description : Queues pixel writes, clips to the screen, and drives the
//               framebuffer write port. Also provides a full-screen clear.
//               Optional macro PIXEL_WRITE_STATS_EN adds clip/drop counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pixel_write_buffer #(
    parameter int DEPTH    = 16,
    parameter int SCREEN_W = 320,
    parameter int SCREEN_H = 240,
    parameter int ADDR_W   = 17
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     pix_valid,
    input  logic [8:0]               pix_x,
    input  logic [7:0]               pix_y,
    input  logic [11:0]              pix_color,
    output logic                     pix_ready,
    input  logic                     clear_req,
    input  logic [11:0]              clear_color,
    output logic                     clear_busy,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [11:0]              mem_data,
    output logic                     mem_we,
    output logic [$clog2(DEPTH):0]   fifo_count,
`ifdef PIXEL_WRITE_STATS_EN
    output logic                     overflow,
    output logic [15:0]              clip_count,
    output logic [15:0]              drop_count
`else
    output logic                     overflow
`endif
);

    localparam int c_PW = $clog2(DEPTH);
    localparam int c_CW = c_PW + 1;
    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(SCREEN_W * SCREEN_H - 1);
    localparam logic [31:0] c_W = SCREEN_W;
    localparam logic [31:0] c_H = SCREEN_H;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CLR_WAIT = 2'd1,
        CLR      = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [28:0]       fifo_mem [DEPTH];
    logic [c_PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [c_CW-1:0]   count_q;
    logic              push, pop;

    logic              p_valid_q;
    logic [8:0]        p_x_q;
    logic [7:0]        p_y_q;
    logic [11:0]       p_color_q;

    logic [ADDR_W-1:0] pix_addr;
    logic              in_bounds;

    logic [ADDR_W-1:0] clr_addr_q;
    logic [11:0]       clr_color_q;

    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [11:0]       mem_data_q;
    logic              overflow_q;

    assign pix_ready  = (count_q < c_CW'(DEPTH)) && (state_q == IDLE);
    assign push       = pix_valid && pix_ready;
    assign pop        = (count_q != '0) && ((state_q == IDLE) || (state_q == CLR_WAIT));
    assign clear_busy = (state_q != IDLE);
    assign fifo_count = count_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_data   = mem_data_q;
    assign overflow   = overflow_q;

    // Storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {pix_x, pix_y, pix_color};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            p_valid_q <= 1'b0;
            p_x_q     <= '0;
            p_y_q     <= '0;
            p_color_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            p_valid_q <= pop;
            if (pop) begin
                {p_x_q, p_y_q, p_color_q} <= fifo_mem[rd_ptr_q];
            end
        end
    end

    generate
        if (SCREEN_W == 320) begin : g_addr_shift
            assign pix_addr = (ADDR_W'(p_y_q) << 8) + (ADDR_W'(p_y_q) << 6) + ADDR_W'(p_x_q);
        end else begin : g_addr_mul
            assign pix_addr = ADDR_W'(p_y_q) * ADDR_W'(SCREEN_W) + ADDR_W'(p_x_q);
        end
    endgenerate

    assign in_bounds = ({23'd0, p_x_q} < c_W) && ({24'd0, p_y_q} < c_H);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (clear_req) state_d = CLR_WAIT;
            // The last queued pixel must leave the pipeline before the clear starts.
            CLR_WAIT: if ((count_q == '0) && !p_valid_q) state_d = CLR;
            CLR:      if (clr_addr_q == c_LAST_ADDR) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            clr_addr_q  <= '0;
            clr_color_q <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if ((state_q == IDLE) && clear_req) begin
                clr_color_q <= clear_color;
                clr_addr_q  <= '0;
            end else if (state_q == CLR) begin
                clr_addr_q  <= clr_addr_q + 1'b1;
            end
            if (state_q == CLR) begin
                mem_we_q   <= 1'b1;
                mem_addr_q <= clr_addr_q;
                mem_data_q <= clr_color_q;
            end else begin
                mem_we_q <= p_valid_q && in_bounds;
                if (p_valid_q && in_bounds) begin
                    mem_addr_q <= pix_addr;
                    mem_data_q <= p_color_q;
                end
            end
            if (pix_valid && !pix_ready) overflow_q <= 1'b1;
        end
    end

`ifdef PIXEL_WRITE_STATS_EN
    logic [15:0] clip_cnt_q, drop_cnt_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            clip_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (p_valid_q && !in_bounds && (clip_cnt_q != 16'hFFFF)) clip_cnt_q <= clip_cnt_q + 1'b1;
            if (pix_valid && !pix_ready && (drop_cnt_q != 16'hFFFF)) drop_cnt_q <= drop_cnt_q + 1'b1;
        end
    end

    assign clip_count = clip_cnt_q;
    assign drop_count = drop_cnt_q;
`endif

endmodule

`default_nettype wire
